// File: rtl/nibble_adder_pkg.sv
// Shared constants for the nibble-serial adder: nibble width and FSM state encoding.
package nibble_adder_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int nibble_count(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit adder with carry in/out; the only arithmetic in the serial adder.
module nibble_add4
    import nibble_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: one nibble per cycle, LSB first, valid/ready on both sides.
module nibble_serial_adder
    import nibble_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    localparam int NIBBLES = nibble_count(WIDTH);
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    logic [1:0]          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [WIDTH-1:0]    sum_q, sum_d;
    logic                carry_q, carry_d;

    logic [NIBBLE_W-1:0] a_nib, b_nib, nib_sum;
    logic                nib_cout;

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
                b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    nibble_add4 u_add4 (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .s    (nib_sum),
        .cout (nib_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = carry_in;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                carry_d = nib_cout;
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDX_W'(i)) sum_d[i*NIBBLE_W +: NIBBLE_W] = nib_sum;
                end
                // Index parks on the last nibble rather than wrapping.
                if (idx_q == LAST_IDX) state_d = ST_DONE;
                else                   idx_d   = idx_q + 1'b1;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign sum       = sum_q;
    assign carry_out = (state_q == ST_DONE) ? carry_q : 1'b0;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed bench for nibble_serial_adder against an arithmetic reference.
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int hs_cnt   = 0;
    int prev_acc = 0;
    bit have_prev = 1'b0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_in_ready"},  64'(in_ready),  64'd1);
        check_val({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check_val({tag, "_busy"},      64'(busy),      64'd0);
        check_val({tag, "_sum"},       64'(sum),       64'd0);
        check_val({tag, "_carry_out"}, 64'(carry_out), 64'd0);
    endtask

    // One full transaction, called and returning at a falling edge.
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic cv, input int hold, input bit inject, input bit b2b);
        logic [WIDTH:0] exp_full;
        int k, lat, hs0, acc_cyc;
        exp_full = {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv};
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_val("in_ready_idle", 64'(in_ready), 64'd1);
        hs0      = hs_cnt;
        a        = av;
        b        = bv;
        carry_in = cv;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        if (b2b && have_prev) check_val("issue_interval", 64'(acc_cyc - prev_acc), 64'd6);
        prev_acc  = acc_cyc;
        have_prev = b2b;
        in_valid  = 1'b0;
        if (inject) begin
            in_valid = 1'b1;
            a        = 16'hAAAA;
            b        = 16'h5555;
            carry_in = 1'b1;
        end
        check_val("busy_run", 64'(busy), 64'd1);
        check_val("in_ready_run", 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check_val("latency", 64'(lat), 64'd4);
        check_val("sum", 64'(sum), 64'(exp_full[WIDTH-1:0]));
        check_val("carry_out", 64'(carry_out), 64'(exp_full[WIDTH]));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_val("hold_out_valid", 64'(out_valid), 64'd1);
            check_val("hold_sum", 64'(sum), 64'(exp_full[WIDTH-1:0]));
            check_val("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!b2b) out_ready = 1'b0;
        check_val("handshakes", 64'(hs_cnt - hs0), 64'd1);
        check_val("idle_out_valid", 64'(out_valid), 64'd0);
        check_val("idle_carry_out", 64'(carry_out), 64'd0);
        if (!b2b) check_val("idle_sum_retained", 64'(sum), 64'(exp_full[WIDTH-1:0]));
    endtask

    initial begin
        int seen_valid;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        carry_in  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;

        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 1'b0);
        run_op(16'h1234, 16'h4321, 1'b1, 0, 1'b0, 1'b0);
        run_op(16'h8F3C, 16'h70C4, 1'b1, 10, 1'b0, 1'b0);
        run_op(16'h0F0F, 16'h00F1, 1'b0, 0, 1'b1, 1'b0);

        // Reset during the second RUN cycle.
        a        = 16'h9999;
        b        = 16'h7777;
        carry_in = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        check_val("no_valid_after_rst", 64'(seen_valid), 64'd0);
        check_reset_outputs("post_rst");

        out_ready = 1'b1;
        have_prev = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 0, 1'b0, 1'b1);
        end
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
